// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-bus interface: SRAM-like req/addr_ok/data_ok read channel.
interface inst_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // Fetch controller side
    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    // Memory / bus side
    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding bus read per PC, stall back to
// the PC register, and a registered {pc, inst, excep, valid} slot toward decode.
module inst_fetch_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned EXCEP_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic [EXCEP_W-1:0]  pc_excep_type_i,
    input  logic                flush_i,
    input  logic                other_stall_i,
    output logic                inst_stall_o,
    inst_fetch_ctrl_if.master   inst_bus,
    output logic [ADDR_W-1:0]   if_pc_o,
    output logic [DATA_W-1:0]   if_inst_o,
    output logic [EXCEP_W-1:0]  if_excep_type_o,
    output logic                if_valid_o
);

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_REQ       = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_HOLD      = 2'd2,
        S_DISCARD   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_req_pc;
    logic [DATA_W-1:0]   r_buf;
    logic [ADDR_W-1:0]   r_if_pc;
    logic [DATA_W-1:0]   r_if_inst;
    logic [EXCEP_W-1:0]  r_if_excep;
    logic                r_if_valid;

    logic                w_fault;
    logic                w_inst_req;
    logic                w_stall;
    logic                w_accept;
    logic                w_buf_load;
    logic                w_deliver;
    logic [ADDR_W-1:0]   w_dlv_pc;
    logic [DATA_W-1:0]   w_dlv_inst;
    logic [EXCEP_W-1:0]  w_dlv_excep;

    assign w_fault = (pc_excep_type_i != '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, bus request, stall and delivery selection
    always_comb begin
        w_state_nxt = r_state;
        w_inst_req  = 1'b0;
        w_stall     = 1'b0;
        w_accept    = 1'b0;
        w_buf_load  = 1'b0;
        w_deliver   = 1'b0;
        w_dlv_pc    = r_req_pc;
        w_dlv_inst  = '0;
        w_dlv_excep = '0;
        unique case (r_state)
            S_REQ: begin
                if (w_fault) begin
                    // Faulting fetch never touches the bus; slot carries the exception
                    if (!flush_i && !other_stall_i) begin
                        w_deliver   = 1'b1;
                        w_dlv_pc    = pc_i;
                        w_dlv_excep = pc_excep_type_i;
                    end
                end else begin
                    w_stall    = 1'b1;
                    w_inst_req = !flush_i;
                    // Request is gated by flush, so an accepted request always waits for data
                    if (w_inst_req && inst_bus.inst_addr_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                w_stall = !inst_bus.inst_data_ok;
                if (inst_bus.inst_data_ok) begin
                    if (flush_i) begin
                        w_state_nxt = S_REQ;
                    end else if (other_stall_i) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_deliver   = 1'b1;
                        w_dlv_inst  = inst_bus.inst_rdata;
                        w_state_nxt = S_REQ;
                    end
                end else if (flush_i) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    w_state_nxt = S_REQ;
                end else if (!other_stall_i) begin
                    w_deliver   = 1'b1;
                    w_dlv_inst  = r_buf;
                    w_state_nxt = S_REQ;
                end
            end
            S_DISCARD: begin
                // Swallow the stale response of a flushed fetch
                w_stall = 1'b1;
                if (inst_bus.inst_data_ok) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // Address of the accepted request
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_pc <= '0;
        end else if (w_accept) begin
            r_req_pc <= pc_i;
        end
    end

    // Instruction buffer for data returned while decode is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf <= '0;
        end else if (w_buf_load) begin
            r_buf <= inst_bus.inst_rdata;
        end
    end

    // Decode slot: flush, then deliver, then stall-hold, else bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_pc    <= '0;
            r_if_inst  <= '0;
            r_if_excep <= '0;
            r_if_valid <= 1'b0;
        end else if (flush_i) begin
            r_if_inst  <= '0;
            r_if_excep <= '0;
            r_if_valid <= 1'b0;
        end else if (w_deliver) begin
            r_if_pc    <= w_dlv_pc;
            r_if_inst  <= w_dlv_inst;
            r_if_excep <= w_dlv_excep;
            r_if_valid <= 1'b1;
        end else if (!other_stall_i) begin
            r_if_inst  <= '0;
            r_if_excep <= '0;
            r_if_valid <= 1'b0;
        end
    end

    assign inst_stall_o        = w_stall;
    assign inst_bus.inst_req   = w_inst_req;
    assign inst_bus.inst_wr    = 1'b0;
    assign inst_bus.inst_size  = SIZE_WORD;
    assign inst_bus.inst_addr  = pc_i;
    assign inst_bus.inst_wdata = '0;

    assign if_pc_o         = r_if_pc;
    assign if_inst_o       = r_if_inst;
    assign if_excep_type_o = r_if_excep;
    assign if_valid_o      = r_if_valid;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a transaction-level reference model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] pc_excep_type_i;
    logic        flush_i;
    logic        other_stall_i;
    logic        inst_stall_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_excep_type_o;
    logic        if_valid_o;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc     = -3;

    inst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .EXCEP_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .pc_excep_type_i (pc_excep_type_i),
        .flush_i         (flush_i),
        .other_stall_i   (other_stall_i),
        .inst_stall_o    (inst_stall_o),
        .inst_bus        (bus),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_excep_type_o (if_excep_type_o),
        .if_valid_o      (if_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, tcyc, act, exp);
        end
    endtask

    // Model: outstanding fetch (live or dead), held instruction, expected slot
    logic        m_live = 1'b0;
    logic        m_out;
    logic        m_dead;
    logic [31:0] m_out_pc;
    logic        m_held;
    logic [31:0] m_held_pc;
    logic [31:0] m_held_inst;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_exc;
    logic        e_valid;

    always @(negedge clk) begin : cmp
        logic        x_req;
        logic        x_stall;
        logic        dlv;
        logic [31:0] d_pc;
        logic [31:0] d_inst;
        logic [31:0] d_exc;
        logic        idle;

        idle    = !m_out && !m_held;
        x_req   = idle && (pc_excep_type_i == 32'd0) && !flush_i;
        if (m_held)      x_stall = 1'b0;
        else if (m_out)  x_stall = m_dead ? 1'b1 : !bus.inst_data_ok;
        else             x_stall = (pc_excep_type_i == 32'd0);

        if (m_live) begin
            chk("inst_req",   64'(bus.inst_req),   64'(x_req));
            chk("inst_stall", 64'(inst_stall_o),   64'(x_stall));
            chk("inst_addr",  64'(bus.inst_addr),  64'(pc_i));
            chk("inst_wr",    64'(bus.inst_wr),    64'd0);
            chk("inst_size",  64'(bus.inst_size),  64'd2);
            chk("inst_wdata", 64'(bus.inst_wdata), 64'd0);
            chk("if_valid",   64'(if_valid_o),     64'(e_valid));
            chk("if_inst",    64'(if_inst_o),      64'(e_inst));
            chk("if_excep",   64'(if_excep_type_o), 64'(e_exc));
            chk("if_pc",      64'(if_pc_o),        64'(e_pc));

            // Hand-computed anchors for the model
            case (tcyc)
                0, 2:  chk("lit_stall_wait", 64'(inst_stall_o), 64'd1);
                1:     chk("lit_req_c1", 64'(bus.inst_req), 64'd1);
                3:     chk("lit_stall_dataok", 64'(inst_stall_o), 64'd0);
                4: begin
                    chk("lit_pc_c4",   64'(if_pc_o),   64'hbfc00000);
                    chk("lit_inst_c4", 64'(if_inst_o), 64'h24080001);
                    chk("lit_valid_c4", 64'(if_valid_o), 64'd1);
                    chk("lit_fault_noreq", 64'(bus.inst_req), 64'd0);
                    chk("lit_fault_nostall", 64'(inst_stall_o), 64'd0);
                end
                5: begin
                    chk("lit_fault_valid", 64'(if_valid_o), 64'd1);
                    chk("lit_fault_inst",  64'(if_inst_o), 64'd0);
                    chk("lit_fault_exc",   64'(if_excep_type_o), 64'h80000000);
                end
                7:  chk("lit_hold_stall", 64'(inst_stall_o), 64'd0);
                9:  chk("lit_hold_inst", 64'(if_inst_o), 64'd0);
                10: begin
                    chk("lit_unhold_inst", 64'(if_inst_o), 64'h8c020004);
                    chk("lit_unhold_pc",   64'(if_pc_o), 64'hbfc00004);
                end
                12: chk("lit_discard_stall", 64'(inst_stall_o), 64'd1);
                14: begin
                    chk("lit_redirect_req",  64'(bus.inst_req), 64'd1);
                    chk("lit_redirect_addr", 64'(bus.inst_addr), 64'hbfc00380);
                    chk("lit_dropped_valid", 64'(if_valid_o), 64'd0);
                end
                17: chk("lit_redirect_pc", 64'(if_pc_o), 64'hbfc00380);
                20: chk("lit_holdflush_valid", 64'(if_valid_o), 64'd0);
                24: chk("lit_zw_pc0", 64'(if_pc_o), 64'hbfc00000);
                25: chk("lit_zw_bubble", 64'(if_valid_o), 64'd0);
                26: chk("lit_zw_pc1", 64'(if_pc_o), 64'hbfc00004);
                28: chk("lit_zw_pc2", 64'(if_pc_o), 64'hbfc00008);
                30: chk("lit_fault_late_exc", 64'(if_excep_type_o), 64'h00000010);
                32: begin
                    chk("lit_rst_req",   64'(bus.inst_req), 64'd1);
                    chk("lit_rst_valid", 64'(if_valid_o), 64'd0);
                end
                35: chk("lit_post_rst_inst", 64'(if_inst_o), 64'h12345678);
                default: ;
            endcase
        end

        // Advance model to the next cycle
        if (!rst) begin
            m_live = 1'b1;
            m_out = 1'b0; m_dead = 1'b0; m_out_pc = '0;
            m_held = 1'b0; m_held_pc = '0; m_held_inst = '0;
            e_pc = '0; e_inst = '0; e_exc = '0; e_valid = 1'b0;
        end else if (m_live) begin
            dlv = 1'b0; d_pc = '0; d_inst = '0; d_exc = '0;
            if (m_held) begin
                if (flush_i) begin
                    m_held = 1'b0;
                end else if (!other_stall_i) begin
                    dlv = 1'b1; d_pc = m_held_pc; d_inst = m_held_inst;
                    m_held = 1'b0;
                end
            end else if (m_out) begin
                if (bus.inst_data_ok) begin
                    if (!m_dead && !flush_i) begin
                        if (other_stall_i) begin
                            m_held = 1'b1; m_held_pc = m_out_pc; m_held_inst = bus.inst_rdata;
                        end else begin
                            dlv = 1'b1; d_pc = m_out_pc; d_inst = bus.inst_rdata;
                        end
                    end
                    m_out = 1'b0; m_dead = 1'b0;
                end else if (flush_i) begin
                    m_dead = 1'b1;
                end
            end else if (pc_excep_type_i != 32'd0) begin
                if (!flush_i && !other_stall_i) begin
                    dlv = 1'b1; d_pc = pc_i; d_exc = pc_excep_type_i;
                end
            end else if (x_req && bus.inst_addr_ok) begin
                m_out = 1'b1; m_dead = 1'b0; m_out_pc = pc_i;
            end

            if (flush_i) begin
                e_valid = 1'b0; e_inst = '0; e_exc = '0;
            end else if (dlv) begin
                e_valid = 1'b1; e_pc = d_pc; e_inst = d_inst; e_exc = d_exc;
            end else if (!other_stall_i) begin
                e_valid = 1'b0; e_inst = '0; e_exc = '0;
            end
        end
    end

    // One cycle of stimulus: drive after the rising edge, settle to the falling edge
    task automatic cyc(input logic r, input logic [31:0] pc, input logic [31:0] ex,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input logic fl, input logic os);
        @(posedge clk);
        #1;
        tcyc++;
        rst               = r;
        pc_i              = pc;
        pc_excep_type_i   = ex;
        bus.inst_addr_ok  = aok;
        bus.inst_data_ok  = dok;
        bus.inst_rdata    = rd;
        flush_i           = fl;
        other_stall_i     = os;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; pc_i = 32'hbfc00000; pc_excep_type_i = '0;
        flush_i = 1'b0; other_stall_i = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;

        cyc(0, 32'hbfc00000, 0, 0, 0, 0, 0, 0);            // -2
        cyc(0, 32'hbfc00000, 0, 0, 0, 0, 0, 0);            // -1
        // Boot fetch with delayed addr_ok/data_ok
        cyc(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0);            // 0
        cyc(1, 32'hbfc00000, 0, 1, 0, 0, 0, 0);            // 1
        cyc(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0);            // 2
        cyc(1, 32'hbfc00000, 0, 0, 1, 32'h24080001, 0, 0); // 3
        // Faulting fetch
        cyc(1, 32'hbfc00002, 32'h80000000, 0, 0, 0, 0, 0); // 4
        // Data returned under decode stall
        cyc(1, 32'hbfc00004, 0, 1, 0, 0, 0, 0);            // 5
        cyc(1, 32'hbfc00004, 0, 0, 1, 32'h8c020004, 0, 1); // 6
        cyc(1, 32'hbfc00004, 0, 0, 0, 0, 0, 1);            // 7
        cyc(1, 32'hbfc00004, 0, 0, 0, 0, 0, 1);            // 8
        cyc(1, 32'hbfc00004, 0, 0, 0, 0, 0, 0);            // 9
        // Flush while waiting for data
        cyc(1, 32'hbfc00008, 0, 1, 0, 0, 0, 0);            // 10
        cyc(1, 32'hbfc00380, 0, 0, 0, 0, 1, 0);            // 11
        cyc(1, 32'hbfc00380, 0, 0, 0, 0, 0, 0);            // 12
        cyc(1, 32'hbfc00380, 0, 0, 1, 32'hdeadbeef, 0, 0); // 13
        cyc(1, 32'hbfc00380, 0, 1, 0, 0, 0, 0);            // 14
        cyc(1, 32'hbfc00380, 0, 0, 0, 0, 0, 0);            // 15
        cyc(1, 32'hbfc00380, 0, 0, 1, 32'h00000001, 0, 0); // 16
        // Flush while holding a buffered instruction
        cyc(1, 32'hbfc00384, 0, 1, 0, 0, 0, 0);            // 17
        cyc(1, 32'hbfc00384, 0, 0, 1, 32'h11111111, 0, 1); // 18
        cyc(1, 32'hbfc00180, 0, 0, 0, 0, 1, 1);            // 19
        cyc(1, 32'hbfc00180, 0, 1, 0, 0, 0, 0);            // 20
        cyc(1, 32'hbfc00180, 0, 0, 1, 32'h22222222, 0, 0); // 21
        // Zero-wait bus, three sequential fetches
        cyc(1, 32'hbfc00000, 0, 1, 0, 0, 0, 0);            // 22
        cyc(1, 32'hbfc00000, 0, 0, 1, 32'h0000000a, 0, 0); // 23
        cyc(1, 32'hbfc00004, 0, 1, 0, 0, 0, 0);            // 24
        cyc(1, 32'hbfc00004, 0, 0, 1, 32'h0000000b, 0, 0); // 25
        cyc(1, 32'hbfc00008, 0, 1, 0, 0, 0, 0);            // 26
        cyc(1, 32'hbfc00008, 0, 0, 1, 32'h0000000c, 0, 0); // 27
        // Fault slot blocked by decode stall, then released
        cyc(1, 32'hbfc00040, 32'h00000010, 0, 0, 0, 0, 1); // 28
        cyc(1, 32'hbfc00040, 32'h00000010, 0, 0, 0, 0, 0); // 29
        // Reset in the middle of a transaction
        cyc(1, 32'hbfc00044, 0, 1, 0, 0, 0, 0);            // 30
        cyc(0, 32'hbfc00044, 0, 0, 0, 0, 0, 0);            // 31
        cyc(1, 32'hbfc00000, 0, 0, 0, 0, 0, 0);            // 32
        cyc(1, 32'hbfc00000, 0, 1, 0, 0, 0, 0);            // 33
        cyc(1, 32'hbfc00000, 0, 0, 1, 32'h12345678, 0, 0); // 34
        cyc(1, 32'hbfc00004, 32'h00000004, 0, 0, 0, 1, 0); // 35
        cyc(1, 32'hbfc00004, 32'h00000004, 0, 0, 0, 0, 0); // 36

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
